// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter_pkg: shared types for the fetch/data memory arbiter.
// Holds the arbiter state encoding used by the RTL and anything probing it.
package cpu_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      MEM_ARB_IDLE   = 3'd0,
      MEM_ARB_CMD_I  = 3'd1,
      MEM_ARB_CMD_D  = 3'd2,
      MEM_ARB_RESP_I = 3'd3,
      MEM_ARB_RESP_D = 3'd4,
      MEM_ARB_DRAIN  = 3'd5
   } arb_state_t;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: one-outstanding memory port shared by fetch and data.
// Data wins ties; fetch responses cancelled by a redirect are drained.
module cpu_mem_arbiter
   import cpu_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   input  logic                    if_kill,
   output logic                    if_ready,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   output logic                    d_ready,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    stall_f,
   output logic                    stall_m
);

   localparam int SW = DATA_WIDTH / 8;

   arb_state_t state;
   arb_state_t state_nx;

   logic                  kill_pend;
   logic                  cmd_we;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [SW-1:0]         cmd_wstrb;

   logic grant_d;
   logic grant_i;
   logic accept;

   assign grant_d = (state == MEM_ARB_IDLE) && d_req;
   assign grant_i = (state == MEM_ARB_IDLE) && !d_req
                    && if_req && !if_kill;
   assign accept  = mem_valid && mem_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MEM_ARB_IDLE;
      else        state <= state_nx;
   end

   // Next-state: serialise one transaction, drain killed fetches.
   always_comb begin
      state_nx = state;
      unique case (state)
         MEM_ARB_IDLE: begin
            if (grant_d)      state_nx = MEM_ARB_CMD_D;
            else if (grant_i) state_nx = MEM_ARB_CMD_I;
         end
         MEM_ARB_CMD_D: begin
            if (mem_ready) state_nx = MEM_ARB_RESP_D;
         end
         MEM_ARB_CMD_I: begin
            if (mem_ready)
               state_nx = (if_kill || kill_pend) ? MEM_ARB_DRAIN
                                                 : MEM_ARB_RESP_I;
         end
         MEM_ARB_RESP_D: begin
            if (mem_rvalid) state_nx = MEM_ARB_IDLE;
         end
         MEM_ARB_RESP_I: begin
            if (mem_rvalid)   state_nx = MEM_ARB_IDLE;
            else if (if_kill) state_nx = MEM_ARB_DRAIN;
         end
         MEM_ARB_DRAIN: begin
            if (mem_rvalid) state_nx = MEM_ARB_IDLE;
         end
         default: state_nx = MEM_ARB_IDLE;
      endcase
   end

   // Outputs: command from registers, responses passed straight through.
   always_comb begin
      mem_valid = (state == MEM_ARB_CMD_I) || (state == MEM_ARB_CMD_D);
      mem_we    = cmd_we;
      mem_addr  = cmd_addr;
      mem_wdata = cmd_wdata;
      mem_wstrb = cmd_wstrb;
      d_ready   = (state == MEM_ARB_RESP_D) && mem_rvalid;
      if_ready  = (state == MEM_ARB_RESP_I) && mem_rvalid && !if_kill;
      d_rdata   = mem_rdata;
      if_rdata  = mem_rdata;
      stall_f   = if_req && !if_ready;
      stall_m   = d_req && !d_ready;
   end

   // Command registers load only on a grant, so they hold while valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_wstrb <= '0;
      end else if (grant_d) begin
         cmd_we    <= d_we;
         cmd_addr  <= d_addr;
         cmd_wdata <= d_wdata;
         cmd_wstrb <= d_we ? d_wstrb : '0;
      end else if (grant_i) begin
         cmd_we    <= 1'b0;
         cmd_addr  <= if_addr;
         cmd_wdata <= '0;
         cmd_wstrb <= '0;
      end
   end

   // Remember a redirect seen while the fetch command waits for accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         kill_pend <= 1'b0;
      else if (state == MEM_ARB_CMD_I && !accept)
         kill_pend <= kill_pend || if_kill;
      else
         kill_pend <= 1'b0;
   end

endmodule
